// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One BCD digit: mod-(MAX+1) counter with carry out when it rolls over.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = ONES_MAX
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic [3:0] value_o,
    output logic       carry_o
);

    logic [3:0] value_q, value_d;

    // >= keeps the digit legal even if it were ever out of range
    assign carry_o = enable_i && (value_q >= MAX);
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = 4'd0;
        end else if (enable_i) begin
            value_d = (value_q >= MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) value_q <= 4'd0;
        else       value_q <= value_d;
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch advanced by rising edges of an in-domain tick level.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        sec_pulse,
    output logic        wrap
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    sw_state_e     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q;
    logic          sec_pulse_q, wrap_q;
    logic          tick_edge, count_en, adv;
    logic [4:0]    en;
    logic [3:0][3:0] digits;

    // Edge in the same cycle as the start_stop leaving RUN still counts
    assign tick_edge = tick_in && !tick_q;
    assign count_en  = (state_q == RUN) && tick_edge && !clear;
    assign adv       = count_en && (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pre_d = pre_q;
        if (clear || state_q == IDLE) begin
            pre_d = '0;
        end else if (count_en) begin
            pre_d = adv ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            tick_q      <= 1'b0;
            sec_pulse_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            tick_q      <= tick_in;
            sec_pulse_q <= adv;
            wrap_q      <= en[4];
        end
    end

    // Digit 0 = sec ones ... digit 3 = min tens; carries ripple upward
    assign en[0] = adv;

    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit #(
            .MAX((g % 2 == 0) ? ONES_MAX : TENS_MAX)
        ) u_dig (
            .clk_i   (clock_in),
            .rst_i   (reset),
            .clear_i (clear),
            .enable_i(en[g]),
            .value_o (digits[g]),
            .carry_o (en[g+1])
        );
    end

    assign bcd_out   = digits;
    assign running   = (state_q == RUN);
    assign sec_pulse = sec_pulse_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench: time-in-seconds reference model predicts every output cycle.
module tb_bcd_stopwatch;

    localparam int TPS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0, tick_in = 1'b0, start_stop = 1'b0, clear = 1'b0;
    logic [15:0] bcd_out;
    logic        running, sec_pulse, wrap;

    bcd_stopwatch #(.TICKS_PER_SEC(TPS)) dut (
        .clock_in  (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .start_stop(start_stop),
        .clear     (clear),
        .bcd_out   (bcd_out),
        .running   (running),
        .sec_pulse (sec_pulse),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        run, pls, wrp;
        bit          dir;
        logic [15:0] dbcd;
        logic        drun;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: mode 0 stopped, 1 running, 2 paused; time kept as whole seconds
    int mode = 0, secs = 0, sub = 0;
    bit prev = 0;

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic step(input bit r, input bit ss, input bit cl, input bit tk);
        exp_t e;
        bit   edge_seen;
        @(negedge clk);
        #1;
        reset = r; start_stop = ss; clear = cl; tick_in = tk;
        e.pls = 0; e.wrp = 0; e.dir = 0; e.dbcd = '0; e.drun = 0; e.name = "";
        if (r) begin
            mode = 0; secs = 0; sub = 0; prev = 0;
        end else begin
            edge_seen = tk && !prev;
            prev = tk;
            if (cl) begin
                mode = 0; secs = 0; sub = 0;
            end else begin
                if (mode == 1 && edge_seen) begin
                    sub++;
                    if (sub == TPS) begin
                        sub = 0;
                        secs = (secs + 1) % 3600;
                        e.pls = 1;
                        e.wrp = (secs == 0);
                    end
                end
                if (ss) mode = (mode == 1) ? 2 : 1;
            end
        end
        e.bcd = to_bcd(secs);
        e.run = (mode == 1);
        @(posedge clk);
        q.push_back(e);
    endtask

    // Attach a fixed expected value to the most recently issued cycle
    task automatic expect_dir(input string nm, input logic [15:0] b, input logic r);
        exp_t e;
        e = q.pop_back();
        e.dir = 1; e.dbcd = b; e.drun = r; e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick(input int gap);
        step(0, 0, 0, 1);
        repeat (gap) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({bcd_out, running, sec_pulse, wrap} !== {e.bcd, e.run, e.pls, e.wrp}) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t: got bcd=%h run=%b pulse=%b wrap=%b, want bcd=%h run=%b pulse=%b wrap=%b",
                             $time, bcd_out, running, sec_pulse, wrap, e.bcd, e.run, e.pls, e.wrp);
                end
                if (e.dir) begin
                    checks++;
                    if ({bcd_out, running} !== {e.dbcd, e.drun}) begin
                        errors++;
                        $display("FAIL %s: got bcd=%h run=%b, want bcd=%h run=%b",
                                 e.name, bcd_out, running, e.dbcd, e.drun);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset, start, four edges -> two seconds
        step(1, 0, 0, 0);
        expect_dir("reset_state", 16'h0000, 1'b0);
        step(0, 1, 0, 0);
        repeat (4) tick($urandom_range(0, 2));
        expect_dir("two_seconds", 16'h0002, 1'b1);

        // Run up to 59:58, then four edges roll over to 00:00
        while (secs != 3598) tick(0);
        expect_dir("at_5958", 16'h5958, 1'b1);
        repeat (4) tick($urandom_range(0, 1));
        expect_dir("rollover", 16'h0000, 1'b1);

        // Pause with a half-second pending, edges ignored, resume completes it
        while (secs != 3) tick(0);
        tick(0);
        step(0, 1, 0, 0);
        repeat (6) tick($urandom_range(0, 2));
        expect_dir("paused_hold", 16'h0003, 1'b0);
        step(0, 1, 0, 0);
        tick(0);
        expect_dir("resume_one_edge", 16'h0004, 1'b1);

        // clear and start_stop together at 01:07
        while (secs != 67) tick(0);
        expect_dir("at_0107", 16'h0107, 1'b1);
        step(0, 1, 1, 0);
        expect_dir("clear_priority", 16'h0000, 1'b0);

        // Start coincident with an edge: that edge is ignored
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        tick(0);
        expect_dir("start_edge_ignored", 16'h0000, 1'b1);
        tick(0);
        expect_dir("first_second", 16'h0001, 1'b1);

        // Reset mid-run at 02:30 with a partial second pending
        while (secs != 150) tick(0);
        tick(0);
        expect_dir("at_0230", 16'h0230, 1'b1);
        step(1, 0, 0, 0);
        expect_dir("reset_midrun", 16'h0000, 1'b0);
        repeat (4) tick($urandom_range(0, 1));
        expect_dir("idle_after_reset", 16'h0000, 1'b0);

        // Randomized commands and tick levels
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 25) == 0,
                 ($urandom % 60) == 0, $urandom % 2);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100: tick rising edges per one-second advance; legal range 1..1000.
REQ-002 SHALL have port clock_in, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port tick_in, input, 1: level output of the upstream clock divider, generated from clock_in and consumed as data, not as a clock.
REQ-005 SHALL have port start_stop, input, 1: single-cycle command pulse toggling run/pause.
REQ-006 SHALL have port clear, input, 1: single-cycle command pulse returning the count to 00:00.
REQ-007 SHALL have port bcd_out, output, 16: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
REQ-008 SHALL have port running, output, 1: high while in RUN.
REQ-009 SHALL have port sec_pulse, output, 1: one-cycle pulse on each one-second advance.
REQ-010 SHALL have port wrap, output, 1: one-cycle pulse on the 59:59 -> 00:00 rollover.

Function
REQ-011 SHALL register tick_in into tick_q each cycle and define edge = tick_in AND NOT tick_q; no synchronizer, since tick_in is in the clock_in domain.
REQ-012 SHALL implement FSM states IDLE (stopped, count zero), RUN and PAUSE.
REQ-013 SHALL transition IDLE->RUN on start_stop, RUN->PAUSE on start_stop, PAUSE->RUN on start_stop, and any state->IDLE on clear.
REQ-014 SHALL give clear priority over start_stop and edge in the same cycle: count, prescaler and pulses are zeroed and the state is IDLE.
REQ-015 SHALL count edges in a prescaler of width $clog2(TICKS_PER_SEC) bits (minimum 1) only while in RUN.
REQ-016 SHALL ignore an edge coinciding with the start_stop that leaves IDLE or PAUSE; counting begins on the next edge.
REQ-017 SHALL count an edge coinciding with the start_stop that leaves RUN; the pause takes effect afterwards.
REQ-018 SHALL, when an edge arrives with the prescaler at TICKS_PER_SEC-1, reset the prescaler to 0 and advance the seconds by one; otherwise the prescaler increments.
REQ-019 SHALL show the advance on bcd_out and sec_pulse in the cycle after the edge cycle (one-cycle latency).
REQ-020 SHALL cascade the digits as sec ones 0..9 -> sec tens 0..5 -> min ones 0..9 -> min tens 0..5, each carrying only when all lower digits are at their maximum.
REQ-021 SHALL roll 59:59 over to 00:00 and assert wrap together with sec_pulse for that cycle; the state remains RUN.
REQ-022 SHALL hold the count and the prescaler value in PAUSE and ignore edges there.
REQ-023 SHALL enter RUN from IDLE with the prescaler at 0.
REQ-024 SHALL never drive a BCD digit outside its legal range.
REQ-025 SHALL drive running combinationally from the state register (registered FSM, no extra delay).

Reset
REQ-026 SHALL, on reset high at a clock edge, set state=IDLE, bcd_out=16'h0000, prescaler=0, tick_q=0, running=0, sec_pulse=0 and wrap=0.
REQ-027 SHALL give reset priority over clear, start_stop and edge.
REQ-028 SHALL abandon any partial second when reset occurs mid-RUN, with no pulse emitted.

Structure
REQ-029 SHALL place the state enum (IDLE/RUN/PAUSE) and the digit limit constants (9, 5) in package stopwatch_pkg.
REQ-030 SHALL instantiate four copies of one sub-module bcd_digit (mod-(MAX+1) counter with inputs enable and clear, outputs value and carry).

Verification
REQ-031 SHALL cover, with TICKS_PER_SEC=2: reset, start_stop, 4 tick_in rising edges -> bcd_out=16'h0002, exactly two sec_pulse, running=1.
REQ-032 SHALL cover a preload of 16'h5958 in RUN followed by 4 edges -> bcd_out=16'h0000, with wrap high for exactly one cycle coincident with the final sec_pulse.
REQ-033 SHALL cover RUN at 16'h0003 with prescaler=1, then start_stop, then 6 edges -> bcd_out stays 16'h0003, running=0; after a second start_stop, 1 edge -> 16'h0004.
REQ-034 SHALL cover clear and start_stop asserted in the same cycle during RUN at 16'h0107 -> next cycle bcd_out=16'h0000, state IDLE, running=0.
REQ-035 SHALL cover start_stop from IDLE coincident with a tick edge, followed by 1 more edge -> bcd_out=16'h0000 (coincident edge ignored); after 1 further edge -> 16'h0001.
REQ-036 SHALL cover reset asserted for one cycle mid-RUN at 16'h0230 -> next cycle all outputs zero, state IDLE; the following edges leave bcd_out=16'h0000.
